// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one MultiplierUnit between two requesters.
// Sequences start/done pulses, holds each result for its owner, and flags a watchdog timeout.
module mul_share_arbiter #(
  parameter int unsigned parallelism = 32,
  parameter int unsigned TIMEOUT     = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_usigned,
  input  logic [2*parallelism-1:0]   req_multiplier,
  input  logic [2*parallelism-1:0]   req_multiplicand,
  output logic [1:0]                 resp_valid,
  input  logic [1:0]                 resp_ready,
  output logic [2*parallelism-1:0]   resp_product,
  output logic                       resp_error,
  output logic                       mul_valid,
  output logic                       mul_usigned,
  output logic [parallelism-1:0]     mul_multiplier,
  output logic [parallelism-1:0]     mul_multiplicand,
  input  logic [2*parallelism-1:0]   mul_product,
  input  logic                       mul_res_ready
);

  localparam int unsigned P  = parallelism;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_next;
  logic             r_rr_last, r_owner, r_usigned, r_error;
  logic [P-1:0]     r_mplier, r_mcand;
  logic [2*P-1:0]   r_product;
  logic [CW-1:0]    r_cnt, w_cnt_inc;
  logic             w_grant_id, w_accept, w_timeout, w_resp_hs;

  // Tie goes to the requester that was not served last.
  assign w_grant_id = (req_valid == 2'b11) ? ~r_rr_last : req_valid[1];
  assign w_accept   = (r_state == S_IDLE) && (req_valid != 2'b00);
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_timeout  = (w_cnt_inc == CW'(TIMEOUT - 1));
  assign w_resp_hs  = (r_state == S_RESP) && resp_ready[r_owner];

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    resp_valid   = '0;
    mul_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready[w_grant_id] = 1'b1;
          w_state_next          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_valid    = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mul_res_ready || w_timeout) w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid[r_owner] = 1'b1;
        if (w_resp_hs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign mul_usigned      = r_usigned;
  assign mul_multiplier   = r_mplier;
  assign mul_multiplicand = r_mcand;
  assign resp_product     = r_product;
  assign resp_error       = r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_owner   <= 1'b0;
      r_usigned <= 1'b0;
      r_error   <= 1'b0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner   <= w_grant_id;
            r_rr_last <= w_grant_id;
            r_usigned <= req_usigned[w_grant_id];
            r_mplier  <= w_grant_id ? req_multiplier[2*P-1:P]   : req_multiplier[P-1:0];
            r_mcand   <= w_grant_id ? req_multiplicand[2*P-1:P] : req_multiplicand[P-1:0];
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          // A done pulse in the timeout cycle still counts as normal completion.
          if (mul_res_ready) begin
            r_product <= mul_product;
            r_error   <= 1'b0;
          end else if (w_timeout) begin
            r_product <= '0;
            r_error   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural multiplier of random 1..40-cycle latency.
module tb_mul_share_arbiter;
  localparam int unsigned P  = 32;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = '0, req_ready, req_usigned = '0;
  logic [63:0]   req_multiplier = '0, req_multiplicand = '0;
  logic [1:0]    resp_valid, resp_ready = '0;
  logic [63:0]   resp_product;
  logic          resp_error, mul_valid, mul_usigned, mul_res_ready;
  logic [31:0]   mul_multiplier, mul_multiplicand;
  logic [63:0]   mul_product;

  logic          m_rr = 1'b0, m_busy = 1'b0, m_mute = 1'b0, stray_rr = 1'b0, saw_both = 1'b0;
  int            m_cnt = 0;
  logic [63:0]   m_prod = '0, m_out = '0;
  int            n_pass = 0, n_total = 0;

  assign mul_res_ready = m_rr | stray_rr;
  assign mul_product   = m_out;

  mul_share_arbiter #(.parallelism(P), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_usigned(req_usigned),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_error(resp_error),
    .mul_valid(mul_valid), .mul_usigned(mul_usigned),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .mul_res_ready(mul_res_ready)
  );

  always #5 clk = ~clk;

  // Behavioural MultiplierUnit: one-cycle done pulse after a random latency.
  always @(posedge clk) begin
    m_rr <= 1'b0;
    if (mul_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= int'($urandom_range(40, 1));
      if (mul_usigned)
        m_prod <= {32'b0, mul_multiplier} * {32'b0, mul_multiplicand};
      else
        m_prod <= {{32{mul_multiplier[31]}}, mul_multiplier} *
                  {{32{mul_multiplicand[31]}}, mul_multiplicand};
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (!m_mute) begin
          m_rr  <= 1'b1;
          m_out <= m_prod;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(req_ready) if (req_ready === 2'b11) saw_both = 1'b1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n, output logic rr_prev);
    logic prev;
    n    = 0;
    prev = 1'b0;
    while (resp_valid == 2'b00 && n < 200) begin
      prev = mul_res_ready;
      tick();
      n++;
    end
    rr_prev = prev;
    chk("resp_arrived", {63'b0, resp_valid != 2'b00}, 64'd1);
  endtask

  task automatic run_one(input string tag, input int id, input logic [1:0] keep,
                         input logic [31:0] a, input logic [31:0] b, input logic u,
                         input logic [63:0] exp_prod, input logic exp_err, output int n);
    logic [1:0] oh;
    logic       rrp;
    int         w;
    oh = (id == 1) ? 2'b10 : 2'b01;
    #1;
    w = 0;
    while (req_ready == 2'b00 && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_grant"}, req_ready, oh);
    tick();
    chk({tag, "_mul_valid"}, mul_valid, 1);
    chk({tag, "_mul_a"}, mul_multiplier, a);
    chk({tag, "_mul_b"}, mul_multiplicand, b);
    chk({tag, "_mul_u"}, mul_usigned, u);
    req_valid = req_valid & keep;
    wait_resp(n, rrp);
    chk({tag, "_resp_valid"}, resp_valid, oh);
    chk({tag, "_product"}, resp_product, exp_prod);
    chk({tag, "_error"}, resp_error, exp_err);
    if (!exp_err) chk({tag, "_done_latency"}, rrp, 1);
    resp_ready = oh;
    tick();
    resp_ready = 2'b00;
    chk({tag, "_released"}, resp_valid, 0);
  endtask

  initial begin
    int n;
    logic rrp;

    // Reset and single unsigned request
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_product", resp_product, 0);
    chk("rst_error", resp_error, 0);
    chk("rst_mul_a", mul_multiplier, 0);
    req_multiplier   = {32'd0, 32'd3};
    req_multiplicand = {32'd0, 32'd5};
    req_usigned      = 2'b01;
    req_valid        = 2'b01;
    run_one("t1", 0, 2'b00, 32'd3, 32'd5, 1'b1, 64'd15, 1'b0, n);

    // Fresh reset: tie must go to requester 0 first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_multiplier   = {32'hFFFF_FFFE, 32'd5};
    req_multiplicand = {32'd3, 32'd7};
    req_usigned      = 2'b01;
    req_valid        = 2'b11;
    run_one("t2a", 0, 2'b10, 32'd5, 32'd7, 1'b1, 64'd35, 1'b0, n);
    run_one("t2b", 1, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, n);

    // Both held for four transactions: strict alternation
    req_valid = 2'b11;
    run_one("t3_0", 0, 2'b11, 32'd5, 32'd7, 1'b1, 64'd35, 1'b0, n);
    run_one("t3_1", 1, 2'b11, 32'hFFFF_FFFE, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, n);
    run_one("t3_2", 0, 2'b11, 32'd5, 32'd7, 1'b1, 64'd35, 1'b0, n);
    run_one("t3_3", 1, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, n);

    // Unit never answers: watchdog completion, then normal service
    m_mute           = 1'b1;
    req_multiplier   = {32'd4, 32'd9};
    req_multiplicand = {32'd6, 32'd9};
    req_usigned      = 2'b11;
    req_valid        = 2'b01;
    run_one("t4_to", 0, 2'b00, 32'd9, 32'd9, 1'b1, 64'd0, 1'b1, n);
    chk("t4_timeout_cycles", 64'(n), 64'(TO));
    m_mute    = 1'b0;
    req_valid = 2'b10;
    run_one("t4_ok", 1, 2'b00, 32'd4, 32'd6, 1'b1, 64'd24, 1'b0, n);

    // Owner stalls the response; non-owner ready ignored, no new grant
    req_multiplier   = {32'hFFFF_FFFF, 32'd7};
    req_multiplicand = {32'hFFFF_FFFF, 32'd8};
    req_usigned      = 2'b01;
    req_valid        = 2'b11;
    #1;
    chk("t5_grant", req_ready, 2'b01);
    tick();
    chk("t5_mul_valid", mul_valid, 1);
    req_valid = 2'b10;
    wait_resp(n, rrp);
    chk("t5_product", resp_product, 64'd56);
    resp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_valid", resp_valid, 2'b01);
      chk("t5_hold_product", resp_product, 64'd56);
      chk("t5_no_grant", req_ready, 2'b00);
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    run_one("t5b", 1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd1, 1'b0, n);

    // Reset during WAIT, then a stray done pulse
    m_mute           = 1'b1;
    req_multiplier   = {32'd0, 32'd11};
    req_multiplicand = {32'd0, 32'd13};
    req_usigned      = 2'b01;
    req_valid        = 2'b01;
    #1;
    chk("t6_grant", req_ready, 2'b01);
    tick();
    chk("t6_mul_valid", mul_valid, 1);
    tick();
    rst       = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_mul_valid0", mul_valid, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_product", resp_product, 0);
    chk("t6_error", resp_error, 0);
    chk("t6_mul_a", mul_multiplier, 0);
    stray_rr = 1'b1;
    tick();
    stray_rr = 1'b0;
    repeat (3) tick();
    chk("t6_stray_resp", resp_valid, 0);
    chk("t6_stray_mul", mul_valid, 0);
    m_mute           = 1'b0;
    req_multiplier   = {32'd2, 32'd0};
    req_multiplicand = {32'd21, 32'd0};
    req_usigned      = 2'b10;
    req_valid        = 2'b10;
    run_one("t6_rec", 1, 2'b00, 32'd2, 32'd21, 1'b1, 64'd42, 1'b0, n);

    chk("never_both_ready", saw_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
